serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
- Transaction sequencer that sits directly around serial_adder: upstream it feeds the operands, downstream it consumes the result.
- Accepts operand pairs on a valid/ready input stream and registers them onto add_a/add_b.
- Pulses the adder's reset so its shift registers load, then counts the adder's run cycles.
- Captures add_sum/add_cout and presents them on a valid/ready result stream held until consumed.

Parameters:
- D_W, 4, operand width; must equal the adder's d_w.
- RUN_CYCLES, 6, clocks with add_reset low before the adder result is sampled; legal range >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  one clock; reset is asynchronous and active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  sequencer can accept an operand pair.
- in_a  in  D_W  operand A.
- in_b  in  D_W  operand B.
- add_a  out  D_W  registered operand A to the adder.
- add_b  out  D_W  registered operand B to the adder.
- add_reset  out  1  registered reset to the adder.
- add_sum  in  D_W+1  adder out bus.
- add_cout  in  1  adder cout.
- res_valid  out  1  result held.
- res_ready  in  1  downstream accepts the result.
- res_sum  out  D_W+1  captured add_sum.
- res_cout  out  1  captured add_cout.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset values: state=IDLE, add_reset=1, add_a=add_b=0, cnt=0, res_valid=0, res_sum=0, res_cout=0.
- States: IDLE, LOAD, RUN, HOLD.
- in_ready = (state==IDLE) || (state==HOLD && res_ready). This is a combinational path from res_ready; no other combinational input-to-output paths exist.
- Accept = in_valid && in_ready.
  - On accept: add_a<=in_a, add_b<=in_b, add_reset<=1, state<=LOAD.
  - From HOLD, accept and result handshake complete on the same edge: res_valid<=0.
- LOAD, exactly one cycle: add_reset<=0, cnt<=0, state<=RUN.
- RUN:
  - cnt increments each edge.
  - On the edge where cnt==RUN_CYCLES-1: res_sum<=add_sum, res_cout<=add_cout, res_valid<=1, state<=HOLD.
- HOLD:
  - res_valid, res_sum and res_cout stay stable until res_valid && res_ready.
  - Handshake with no accept: state<=IDLE, res_valid<=0.
  - Handshake with accept: see above.
- Latency: res_valid rises RUN_CYCLES+2 clock edges after the accept edge. Default is 8 edges.
- Back-to-back throughput: one result per RUN_CYCLES+2 cycles.
- add_reset is glitch-free because it comes from a flop, since it drives an asynchronous reset. It is high for exactly the one LOAD cycle per transaction, and otherwise low after reset release.
- add_a/add_b change only on an accept edge and are stable through LOAD and RUN.
- in_valid while not in_ready is ignored; no operand or state change.
- No arithmetic is performed: results are passed through bit-exact from the adder.
- Reset asserted in any state:
  - Immediately forces the reset values, so add_reset=1 and res_valid=0 asynchronously.
  - Any in-flight transaction is dropped; no partial result is ever emitted.
- cnt width = $clog2(RUN_CYCLES+1); cnt never wraps, because RUN exits at RUN_CYCLES-1.

Decomposition:
- Package serial_add_pkg:
  - state enum (IDLE, LOAD, RUN, HOLD);
  - default constants D_W_DEF=4 and RUN_CYCLES_DEF=6;
  - cnt width derivation.
- No sub-module: the counter and the result register are inline.
- The bench instantiates serial_add_seq and serial_adder side by side.

Test Plan:
- Reset: assert reset with in_valid=1 -> in_ready=1, busy=0, res_valid=0, add_reset=1, add_a=add_b=0. After release, add_reset=0 at the next edge.
- Single transaction: in_a=4'h5, in_b=4'h3, res_ready=1.
  - add_reset is high for one cycle only.
  - res_valid is high 8 edges after the accept edge.
  - res_sum/res_cout equal the adder's outputs at the capture edge; this checks the pipeline end to end.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid, with in_valid=1 and in_a=4'hA -> res_valid stays 1, res_sum is unchanged, in_ready=0, add_a is not updated.
- Back-to-back: in_valid held with F+F then 2+1, res_ready=1.
  - The second pair is accepted on the same edge as the first result handshake.
  - No idle bubble; the result spacing is exactly 8 cycles.
- Mid-run reset: pulse reset when cnt=3 -> res_valid=0 and add_reset=1 asynchronously, state=IDLE, and no result is emitted. A following 4'h7+4'h1 transaction completes normally.
- Parameter sweep: RUN_CYCLES=1 and RUN_CYCLES=9 -> latency is 3 and 11 edges respectively, and cnt never exceeds RUN_CYCLES-1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial adder transaction sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int D_W_DEF        = 4;
    localparam int RUN_CYCLES_DEF = 6;

    // Run counter stops at run_cycles-1, so this width never wraps.
    function automatic int cnt_width(input int run_cycles);
        return $clog2(run_cycles + 1);
    endfunction

endpackage

// File: rtl/serial_add_seq.sv
// Feeds operand pairs to a serial adder, pulses its reset to load it,
// waits a fixed number of run cycles and holds the result for downstream.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int D_W        = D_W_DEF,
    parameter int RUN_CYCLES = RUN_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [D_W-1:0] in_a,
    input  logic [D_W-1:0] in_b,
    output logic [D_W-1:0] add_a,
    output logic [D_W-1:0] add_b,
    output logic           add_reset,
    input  logic [D_W:0]   add_sum,
    input  logic           add_cout,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [D_W:0]   res_sum,
    output logic           res_cout,
    output logic           busy
);

    localparam int            CW       = cnt_width(RUN_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(RUN_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          accept;

    // A held result may be replaced in the same edge it is consumed.
    assign in_ready = (state == IDLE) || (state == HOLD && res_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            add_reset <= 1'b1;
            add_a     <= '0;
            add_b     <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: add_reset <= 1'b0;
                LOAD: begin
                    add_reset <= 1'b0;
                    cnt       <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    if (cnt == CNT_LAST) begin
                        res_sum   <= add_sum;
                        res_cout  <= add_cout;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Accept overrides the per-state updates above (IDLE or HOLD only).
            if (accept) begin
                add_a     <= in_a;
                add_b     <= in_b;
                add_reset <= 1'b1;
                state     <= LOAD;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Three sequencers (RUN_CYCLES 6, 1, 9), each beside a behavioural serial adder
// that exposes one more sum bit per clock after its reset drops.
module tb_serial_add_seq;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       iv[N], ir[N], ar[N], ac[N], rv[N], rr[N], rc[N], bz[N];
    logic [3:0] ia[N], ib[N], aa[N], ab[N];
    logic [4:0] as[N], rs[N];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cmp = 0;
    int err = 0;

    generate
        for (genvar g = 0; g < N; g++) begin : gen_dut
            localparam int R = (g == 0) ? 6 : ((g == 1) ? 1 : 9);
            logic [3:0] kk;
            logic [4:0] full, msk;
            logic       arst;

            serial_add_seq #(.D_W(4), .RUN_CYCLES(R)) u_dut (
                .clk(clk), .reset(rst),
                .in_valid(iv[g]), .in_ready(ir[g]), .in_a(ia[g]), .in_b(ib[g]),
                .add_a(aa[g]), .add_b(ab[g]), .add_reset(ar[g]),
                .add_sum(as[g]), .add_cout(ac[g]),
                .res_valid(rv[g]), .res_ready(rr[g]), .res_sum(rs[g]), .res_cout(rc[g]),
                .busy(bz[g])
            );

            assign arst = ar[g];
            always_ff @(posedge clk or posedge arst) begin
                if (arst) kk <= '0;
                else if (kk != 4'hF) kk <= kk + 4'd1;
            end
            assign full  = {1'b0, aa[g]} + {1'b0, ab[g]};
            assign msk   = (kk >= 4'd5) ? 5'h1F : 5'((5'd1 << kk) - 5'd1);
            assign as[g] = full & msk;
            assign ac[g] = (kk >= 4'd4) ? full[4] : 1'b0;
        end
    endgenerate

    function automatic int rc_of(input int g);
        return (g == 0) ? 6 : ((g == 1) ? 1 : 9);
    endfunction

    // Expected {cout, sum}: the adder has shifted RUN_CYCLES-1 bits at capture.
    function automatic logic [5:0] ref_res(input int a, input int b, input int r);
        int k, s, sum, co;
        k   = r - 1;
        s   = a + b;
        sum = (k >= 5) ? s : (s % (1 << k));
        co  = (k >= 4) ? ((s >> 4) & 1) : 0;
        return 6'((co << 5) | sum);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        cmp++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    // Presents one pair, returns the result, latency (edges counting the accept
    // edge), number of cycles add_reset was high, and the adder outputs seen
    // just before the capture edge.
    task automatic run_txn(input int g, input logic [3:0] a, input logic [3:0] b,
                           input logic rdy, output logic [4:0] s, output logic c,
                           output int lat, output int arc,
                           output logic [4:0] ads, output logic adc);
        int acc;
        bit got;
        s = '0; c = 1'b0; lat = 0; arc = 0; ads = '0; adc = 1'b0;
        ia[g] = a; ib[g] = b; iv[g] = 1'b1; rr[g] = rdy;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (ir[g]) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            chk("accept_timeout", 0, 1);
            iv[g] = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(negedge clk);
        iv[g] = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (rv[g]) got = 1;
            else begin
                if (ar[g]) arc++;
                ads = as[g];
                adc = ac[g];
                @(negedge clk);
            end
        end
        if (!got) begin
            chk("result_timeout", 0, 1);
            return;
        end
        lat = cyc - acc + 1;
        s = rs[g];
        c = rc[g];
    endtask

    typedef struct {
        logic [3:0] a, b;
        logic [4:0] sum;
        logic       cout;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [4:0] s, ads, s0;
        logic       c, adc;
        int         lat, arc, t0, hold, bad;
        logic [3:0] ra, rb;
        logic [5:0] e;

        tbl[0] = '{4'h5, 4'h3, 5'h08, 1'b0};
        tbl[1] = '{4'hF, 4'hF, 5'h1E, 1'b1};
        tbl[2] = '{4'h2, 4'h1, 5'h03, 1'b0};
        tbl[3] = '{4'hA, 4'h7, 5'h11, 1'b1};
        tbl[4] = '{4'h0, 4'h0, 5'h00, 1'b0};
        tbl[5] = '{4'h8, 4'h8, 5'h10, 1'b1};

        for (int g = 0; g < N; g++) begin
            iv[g] = 1'b0; rr[g] = 1'b1; ia[g] = '0; ib[g] = '0;
        end
        rst = 1'b1;
        iv[0] = 1'b1; ia[0] = 4'h9; ib[0] = 4'h9;
        #2;
        chk("rst_in_ready", ir[0], 1);
        chk("rst_busy", bz[0], 0);
        chk("rst_res_valid", rv[0], 0);
        chk("rst_add_reset", ar[0], 1);
        chk("rst_add_a", aa[0], 0);
        chk("rst_add_b", ab[0], 0);
        chk("rst_res_sum", rs[0], 0);
        @(negedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_add_reset", ar[0], 0);
        chk("post_rst_busy", bz[0], 0);

        // single transaction, end to end
        run_txn(0, 4'h5, 4'h3, 1'b1, s, c, lat, arc, ads, adc);
        chk("single_latency", lat, 8);
        chk("single_add_reset_cycles", arc, 1);
        chk("single_sum_vs_adder", s, ads);
        chk("single_cout_vs_adder", c, adc);
        chk("single_sum", s, 5'h08);
        chk("single_cout", c, 0);
        @(negedge clk);
        chk("single_consumed", rv[0], 0);
        chk("single_idle", bz[0], 0);

        foreach (tbl[i]) begin
            run_txn(0, tbl[i].a, tbl[i].b, 1'b1, s, c, lat, arc, ads, adc);
            chk("tbl_sum", s, tbl[i].sum);
            chk("tbl_cout", c, tbl[i].cout);
            chk("tbl_latency", lat, 8);
        end
        @(negedge clk);

        // backpressure: result held, new pair ignored
        run_txn(0, 4'h5, 4'h3, 1'b0, s, c, lat, arc, ads, adc);
        ia[0] = 4'hA; ib[0] = 4'h4; iv[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_res_valid", rv[0], 1);
            chk("bp_res_sum", rs[0], 5'h08);
            chk("bp_in_ready", ir[0], 0);
            chk("bp_add_a", aa[0], 4'h5);
        end
        iv[0] = 1'b0; rr[0] = 1'b1;
        @(negedge clk);
        chk("bp_released", rv[0], 0);

        // back-to-back: second accept on the first result's handshake edge
        run_txn(0, 4'hF, 4'hF, 1'b1, s, c, lat, arc, ads, adc);
        t0 = cyc;
        chk("b2b_first_sum", s, 5'h1E);
        chk("b2b_in_ready_in_hold", ir[0], 1);
        run_txn(0, 4'h2, 4'h1, 1'b1, s, c, lat, arc, ads, adc);
        chk("b2b_spacing", cyc - t0, 8);
        chk("b2b_second_sum", s, 5'h03);
        chk("b2b_add_a", aa[0], 4'h2);
        @(negedge clk);

        // reset in the middle of RUN (cnt==3)
        ia[0] = 4'h7; ib[0] = 4'h1; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_busy_before", bz[0], 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_add_reset", ar[0], 1);
        chk("midrst_res_valid", rv[0], 0);
        chk("midrst_busy", bz[0], 0);
        #1 rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rv[0] !== 1'b0 || bz[0] !== 1'b0) bad++;
        end
        chk("midrst_no_result", bad, 0);
        run_txn(0, 4'h7, 4'h1, 1'b1, s, c, lat, arc, ads, adc);
        chk("midrst_after_sum", s, 5'h08);
        chk("midrst_after_cout", c, 0);
        chk("midrst_after_latency", lat, 8);

        // parameter sweep
        for (int g = 1; g < N; g++) begin
            foreach (tbl[i]) begin
                run_txn(g, tbl[i].a, tbl[i].b, 1'b1, s, c, lat, arc, ads, adc);
                e = ref_res(int'(tbl[i].a), int'(tbl[i].b), rc_of(g));
                chk("sweep_latency", lat, rc_of(g) + 2);
                chk("sweep_sum", s, e[4:0]);
                chk("sweep_cout", c, e[5]);
                chk("sweep_sum_vs_adder", s, ads);
            end
        end
        @(negedge clk);

        // random traffic with random result stalls
        for (int n = 0; n < 24; n++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_txn(0, ra, rb, 1'b0, s, c, lat, arc, ads, adc);
            e = ref_res(int'(ra), int'(rb), 6);
            chk("rnd_sum", s, e[4:0]);
            chk("rnd_cout", c, e[5]);
            chk("rnd_latency", lat, 8);
            s0 = rs[0];
            hold = $urandom_range(0, 3);
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (rv[0] !== 1'b1 || rs[0] !== s0) bad++;
            end
            chk("rnd_hold_stable", bad, 0);
            rr[0] = 1'b1;
            @(negedge clk);
            chk("rnd_consumed", rv[0], 0);
        end
        for (int g = 1; g < N; g++) begin
            for (int n = 0; n < 6; n++) begin
                ra = 4'($urandom_range(0, 15));
                rb = 4'($urandom_range(0, 15));
                run_txn(g, ra, rb, 1'b1, s, c, lat, arc, ads, adc);
                e = ref_res(int'(ra), int'(rb), rc_of(g));
                chk("rnd_sweep_sum", s, e[4:0]);
                chk("rnd_sweep_cout", c, e[5]);
                chk("rnd_sweep_latency", lat, rc_of(g) + 2);
            end
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
